// File: rtl/c5_mem_sched_pkg.sv
// Shared constants for the c5 memory scheduler: FSM encodings, opcode constants
// and the pause-release decode shared by the top level.
package c5_mem_sched_pkg;

    localparam int WORD_ADDR_W = 30;

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [31:0] NOP_OPCODE = 32'h0000_0000;
    localparam logic [31:0] ZERO       = 32'h0000_0000;

    // The PC may advance only when a fetch has just completed or a held fetch is released.
    function automatic logic pause_release(input logic [1:0] state,
                                           input logic       ack,
                                           input logic       pause_ext);
        return ((state == S_FETCH) && ack && !pause_ext) ||
               ((state == S_HOLD) && !pause_ext);
    endfunction

endpackage

// File: rtl/c5_mem_sched_wait_timer.sv
// Wait-cycle counter for the scheduler's optional bus timeout (C5_MEM_TIMEOUT_EN).
module c5_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/c5_mem_sched.sv
// Memory port scheduler: arbitrates instruction fetch and load/store onto one port.
// Optional bus timeout is enabled with the C5_MEM_TIMEOUT_EN macro.
module c5_mem_sched
    import c5_mem_sched_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic [WORD_ADDR_W-1:0] I_pc_future,
    input  logic                   I_pause_ext,
    input  logic                   I_data_req,
    input  logic [WORD_ADDR_W-1:0] I_data_addr,
    input  logic [3:0]             I_data_byte_we,
    input  logic [WIDTH-1:0]       I_data_wdata,
    output logic [WIDTH-1:0]       O_data_rdata,
    output logic                   O_data_done,
    output logic [WIDTH-1:0]       O_opcode,
    output logic                   O_pause,
    output logic                   O_mem_req,
    output logic [WORD_ADDR_W-1:0] O_mem_addr,
    output logic [3:0]             O_mem_byte_we,
    output logic [WIDTH-1:0]       O_mem_wdata,
    input  logic                   I_mem_ack,
    input  logic [WIDTH-1:0]       I_mem_rdata,
    output logic                   O_bus_err
);

    logic [1:0]             state_q,  state_d;
    logic                   req_q,    req_d;
    logic [WORD_ADDR_W-1:0] addr_q,   addr_d;
    logic [3:0]             we_q,     we_d;
    logic [WIDTH-1:0]       wdata_q,  wdata_d;
    logic [WIDTH-1:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0]       rdata_q,  rdata_d;
    logic                   done_q,   done_d;

    logic             timeout;
    logic             ack_eff;
    logic [WIDTH-1:0] rdata_eff;

`ifdef C5_MEM_TIMEOUT_EN
    logic expired;

    c5_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (I_clk),
        .rst_ni   (I_rst_n),
        .clear_i  (state_q == S_ISSUE),
        .en_i     (req_q && !I_mem_ack),
        .expired_o(expired)
    );

    // A timed-out access completes like an ack, returning a NOP/zero word.
    assign timeout   = req_q && !I_mem_ack && expired;
    assign rdata_eff = timeout ? WIDTH'(NOP_OPCODE) : I_mem_rdata;
`else
    assign timeout   = 1'b0 && (TIMEOUT_CYCLES != 0);
    assign rdata_eff = I_mem_rdata;
`endif

    assign ack_eff   = req_q && (I_mem_ack || timeout);
    assign O_bus_err = timeout;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        opcode_d = opcode_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        case (state_q)
            S_ISSUE: begin
                req_d = 1'b1;
                if (I_data_req && !done_q) begin
                    state_d = S_DATA;
                    addr_d  = I_data_addr;
                    we_d    = I_data_byte_we;
                    wdata_d = I_data_wdata;
                end else begin
                    state_d = S_FETCH;
                    addr_d  = I_pc_future;
                    we_d    = 4'h0;
                    wdata_d = WIDTH'(ZERO);
                end
            end
            S_FETCH: begin
                if (ack_eff) begin
                    opcode_d = rdata_eff;
                    req_d    = 1'b0;
                    state_d  = I_pause_ext ? S_HOLD : S_ISSUE;
                end
            end
            S_DATA: begin
                if (ack_eff) begin
                    rdata_d = rdata_eff;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (!I_pause_ext) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q  <= S_ISSUE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            opcode_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            opcode_q <= opcode_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
        end
    end

    // Pause is forced high during reset so the PC cannot move before the first fetch.
    assign O_pause = !I_rst_n || !pause_release(state_q, ack_eff, I_pause_ext);

    assign O_mem_req     = req_q;
    assign O_mem_addr    = addr_q;
    assign O_mem_byte_we = we_q;
    assign O_mem_wdata   = wdata_q;
    assign O_opcode      = opcode_q;
    assign O_data_rdata  = rdata_q;
    assign O_data_done   = done_q;

endmodule
